// File: rtl/vga_timing_monitor_pkg.sv
// Shared types and constants for the VGA timing monitor.
package vga_timing_monitor_pkg;

    localparam int unsigned MEAS_W   = 12;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } lock_state_t;

    typedef struct packed {
        logic [MEAS_W-1:0] h_total;
        logic [MEAS_W-1:0] h_active;
        logic [MEAS_W-1:0] v_total;
        logic [MEAS_W-1:0] v_active;
    } meas_t;

endpackage

// File: rtl/vtm_crc16_step.sv
// One-pixel CRC-16-CCITT update over a 24-bit {r,g,b} word, MSB first.
module vtm_crc16_step
    import vga_timing_monitor_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [23:0] data,
    output logic [15:0] crc_out
);

    // Bit-serial shift register unrolled across all 24 data bits
    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < 24; i++) begin
            if (crc_out[15] ^ data[23-i])
                crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
            else
                crc_out = {crc_out[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// Passive video timing monitor: measures line/frame geometry per frame,
// tracks lock to a stable mode and flags loss of vsync.
// Optional per-frame pixel CRC enabled by defining VGA_TIMING_MONITOR_CRC_EN.
module vga_timing_monitor
    import vga_timing_monitor_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT_W   = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic [7:0]        vid_r,
    input  logic [7:0]        vid_g,
    input  logic [7:0]        vid_b,
    output logic [MEAS_W-1:0] h_total_meas,
    output logic [MEAS_W-1:0] h_active_meas,
    output logic [MEAS_W-1:0] v_total_meas,
    output logic [MEAS_W-1:0] v_active_meas,
    output logic              frame_done,
    output logic              locked,
    output logic              lock_lost,
    output logic              no_signal,
    output logic [15:0]       frame_crc
);

    localparam int unsigned            MC_W     = $clog2(LOCK_FRAMES + 1);
    localparam logic [MC_W-1:0]        LOCK_CNT = MC_W'(LOCK_FRAMES);
    localparam logic [TIMEOUT_W-1:0]   WD_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0]   WD_LAST  = WD_MAX - TIMEOUT_W'(1);

    logic              d0_hs, d0_vs, d0_de, d1_hs, d1_vs;
    logic              hs_fall, vs_fall, line_end_active;
    logic [MEAS_W-1:0] h_cnt, line_period, de_cnt, line_active, v_cnt, v_act_cnt;
    logic              armed;
    meas_t             cur, ref_meas;
    logic              frame_match, ref_load;
    logic [MC_W-1:0]   match_cnt, next_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;
    lock_state_t       state;

    assign hs_fall         = d1_hs & ~d0_hs;
    assign vs_fall         = d1_vs & ~d0_vs;
    assign line_end_active = hs_fall && (de_cnt != '0);

    // Input capture (d0) and edge-detect delay (d1); syncs idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d0_hs <= 1'b1;
            d0_vs <= 1'b1;
            d0_de <= 1'b0;
            d1_hs <= 1'b1;
            d1_vs <= 1'b1;
        end else begin
            d0_hs <= vid_hs;
            d0_vs <= vid_vs;
            d0_de <= vid_de;
            d1_hs <= d0_hs;
            d1_vs <= d0_vs;
        end
    end

    // A line ending on the same cycle as vs_fall still belongs to the old frame
    always_comb begin
        cur.h_total  = hs_fall ? h_cnt : line_period;
        cur.h_active = line_end_active ? de_cnt : line_active;
        cur.v_total  = v_cnt;
        cur.v_active = v_act_cnt + {{(MEAS_W-1){1'b0}}, line_end_active};
    end

    // Line and frame counters plus per-frame measurement latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt         <= '0;
            line_period   <= '0;
            de_cnt        <= '0;
            line_active   <= '0;
            v_cnt         <= '0;
            v_act_cnt     <= '0;
            armed         <= 1'b0;
            frame_done    <= 1'b0;
            h_total_meas  <= '0;
            h_active_meas <= '0;
            v_total_meas  <= '0;
            v_active_meas <= '0;
        end else begin
            frame_done <= vs_fall & armed;
            if (hs_fall) begin
                h_cnt       <= '0;
                line_period <= h_cnt;
                de_cnt      <= {{(MEAS_W-1){1'b0}}, d0_de};
                if (de_cnt != '0)
                    line_active <= de_cnt;
            end else begin
                if (h_cnt != '1)
                    h_cnt <= h_cnt + 1'b1;
                if (d0_de && de_cnt != '1)
                    de_cnt <= de_cnt + 1'b1;
            end
            if (vs_fall) begin
                v_cnt     <= '0;
                v_act_cnt <= '0;
                armed     <= 1'b1;
                if (armed) begin
                    h_total_meas  <= cur.h_total;
                    h_active_meas <= cur.h_active;
                    v_total_meas  <= cur.v_total;
                    v_active_meas <= cur.v_active;
                end
            end else begin
                if (hs_fall)
                    v_cnt <= v_cnt + 1'b1;
                if (line_end_active)
                    v_act_cnt <= v_act_cnt + 1'b1;
            end
        end
    end

`ifdef VGA_TIMING_MONITOR_CRC_EN
    logic [23:0] d0_pix;
    logic [15:0] crc_run, crc_seed, crc_next, ref_crc;

    assign crc_seed    = vs_fall ? CRC_INIT : crc_run;
    assign frame_match = (cur == ref_meas) && (crc_run == ref_crc);

    vtm_crc16_step u_crc16_step (
        .crc_in  (crc_seed),
        .data    (d0_pix),
        .crc_out (crc_next)
    );

    // Pixel capture, running frame CRC and its reference copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d0_pix    <= '0;
            crc_run   <= CRC_INIT;
            frame_crc <= CRC_INIT;
            ref_crc   <= '0;
        end else begin
            d0_pix  <= {vid_r, vid_g, vid_b};
            crc_run <= d0_de ? crc_next : crc_seed;
            if (vs_fall && armed)
                frame_crc <= crc_run;
            if (ref_load)
                ref_crc <= crc_run;
        end
    end
`else
    logic unused_pix;
    assign unused_pix  = ^{vid_r, vid_g, vid_b};
    assign frame_match = (cur == ref_meas);
    assign frame_crc   = '0;
`endif

    assign next_cnt = frame_match ? match_cnt + 1'b1 : MC_W'(1);
    assign ref_load = vs_fall && armed &&
                      ((state == ACQUIRE) || (state == LOCKED && !frame_match));

    // Lock FSM with vsync watchdog; vs_fall always restarts the watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            match_cnt <= '0;
            ref_meas  <= '0;
            wd_cnt    <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            no_signal <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            if (ref_load)
                ref_meas <= cur;
            if (vs_fall) begin
                wd_cnt    <= '0;
                no_signal <= 1'b0;
                case (state)
                    IDLE: begin
                        state     <= ACQUIRE;
                        match_cnt <= '0;
                    end
                    ACQUIRE: begin
                        if (armed) begin
                            match_cnt <= next_cnt;
                            if (next_cnt >= LOCK_CNT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (armed && !frame_match) begin
                            state     <= ACQUIRE;
                            match_cnt <= MC_W'(1);
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (wd_cnt == WD_LAST) begin
                wd_cnt    <= WD_MAX;
                no_signal <= 1'b1;
                state     <= IDLE;
                match_cnt <= '0;
                locked    <= 1'b0;
                lock_lost <= (state == LOCKED);
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor: 16 clk/line, 8-clk de, 10 lines,
// 5 active lines, LOCK_FRAMES=2, TIMEOUT_W=8.
module tb_vga_timing_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_hs, vid_vs, vid_de;
    logic [7:0]  vid_r, vid_g, vid_b;
    logic [11:0] h_total_meas, h_active_meas, v_total_meas, v_active_meas;
    logic        frame_done, locked, lock_lost, no_signal;
    logic [15:0] frame_crc;

    int checks   = 0;
    int failures = 0;

    // Values captured at the frame_done cycle seen during a run_frame call
    int          fd_cnt, done_tick, tick_no;
    logic [11:0] c_ht, c_ha, c_vt, c_va;
    logic        c_locked, c_lost;
    logic [15:0] c_crc;
    int          n_ticks;
    logic [15:0] exp_crc_rst;

    vga_timing_monitor #(.LOCK_FRAMES(2), .TIMEOUT_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vid_hs        (vid_hs),
        .vid_vs        (vid_vs),
        .vid_de        (vid_de),
        .vid_r         (vid_r),
        .vid_g         (vid_g),
        .vid_b         (vid_b),
        .h_total_meas  (h_total_meas),
        .h_active_meas (h_active_meas),
        .v_total_meas  (v_total_meas),
        .v_active_meas (v_active_meas),
        .frame_done    (frame_done),
        .locked        (locked),
        .lock_lost     (lock_lost),
        .no_signal     (no_signal),
        .frame_crc     (frame_crc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of video, then sample #1 after the edge
    task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] pix);
        vid_hs = hs; vid_vs = vs; vid_de = de;
        {vid_r, vid_g, vid_b} = pix;
        @(posedge clk);
        #1;
        tick_no++;
        if (frame_done) begin
            fd_cnt++;
            done_tick = tick_no;
            c_ht = h_total_meas; c_ha = h_active_meas;
            c_vt = v_total_meas; c_va = v_active_meas;
            c_locked = locked; c_lost = lock_lost; c_crc = frame_crc;
        end
    endtask

    // Frame with hs+vs falling together at line 0; flip_idx selects a pixel
    // to replace (negative = none); stops after max_ticks clocks
    task automatic run_frame(input int de_w, input int flip_idx, input int max_ticks);
        int pix_idx;
        logic de;
        logic [23:0] pix;
        fd_cnt = 0; done_tick = 0; tick_no = 0; pix_idx = 0;
        c_lost = 1'b0;
        for (int l = 0; l < 10; l++) begin
            for (int c = 0; c < 16; c++) begin
                if (tick_no < max_ticks) begin
                    de  = (l < 5) && (c >= 4) && (c < 4 + de_w);
                    pix = 24'hFF0000;
                    if (de) begin
                        if (pix_idx == flip_idx) pix = 24'h00FF00;
                        pix_idx++;
                    end
                    tick(c >= 2, l >= 2, de, pix);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    function automatic logic [15:0] crc_ref(input int npix, input int flip_idx);
        logic [15:0] crc;
        logic [23:0] p;
        crc = 16'hFFFF;
        for (int k = 0; k < npix; k++) begin
            p = (k == flip_idx) ? 24'h00FF00 : 24'hFF0000;
            for (int b = 23; b >= 0; b--) begin
                if (crc[15] ^ p[b]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
                else                crc = {crc[14:0], 1'b0};
            end
        end
        return crc;
    endfunction

    initial begin
`ifdef VGA_TIMING_MONITOR_CRC_EN
        exp_crc_rst = 16'hFFFF;
`else
        exp_crc_rst = 16'h0000;
`endif
        reset_n = 1'b0;
        tick_no = 0;
        idle(3);
        check("rst_h_total", 32'(h_total_meas), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_no_signal", 32'(no_signal), 0);
        check("rst_frame_crc", 32'(frame_crc), 32'(exp_crc_rst));
        reset_n = 1'b1;
        idle(2);

        // A: first vs_fall only arms
        run_frame(8, -1, 160);
        check("arm_no_done", fd_cnt, 0);

        // B: completes A
        run_frame(8, -1, 160);
        check("B_done_cnt", fd_cnt, 1);
        check("B_done_latency", done_tick, 2);
        check("B_h_total", 32'(c_ht), 15);
        check("B_h_active", 32'(c_ha), 8);
        check("B_v_total", 32'(c_vt), 9);
        check("B_v_active", 32'(c_va), 5);
        check("B_locked", 32'(c_locked), 0);
`ifdef VGA_TIMING_MONITOR_CRC_EN
        check("B_crc", 32'(c_crc), 32'(crc_ref(40, -1)));
`else
        check("B_crc", 32'(c_crc), 0);
`endif

        // C: second matching frame locks
        run_frame(8, -1, 160);
        check("C_locked", 32'(c_locked), 1);
        check("C_lock_lost", 32'(c_lost), 0);
`ifdef VGA_TIMING_MONITOR_CRC_EN
        check("C_crc_stable", 32'(c_crc), 32'(crc_ref(40, -1)));
`endif

        // D, E: width 6 breaks lock on completion of D
        run_frame(6, -1, 160);
        check("D_still_locked", 32'(c_locked), 1);
        run_frame(6, -1, 160);
        check("E_h_active", 32'(c_ha), 6);
        check("E_locked", 32'(c_locked), 0);
        check("E_lock_lost", 32'(c_lost), 1);

        // F: relock one frame later
        run_frame(6, -1, 160);
        check("F_relocked", 32'(c_locked), 1);

        // Watchdog: last vs_fall registered on tick 2 of F -> expiry 97 ticks after F
        n_ticks = 0;
        while (!no_signal && n_ticks < 400) begin
            tick(1'b1, 1'b1, 1'b0, 24'h0);
            n_ticks++;
        end
        check("wd_ticks", n_ticks, 97);
        check("wd_no_signal", 32'(no_signal), 1);
        check("wd_lock_lost", 32'(lock_lost), 1);
        check("wd_locked", 32'(locked), 0);
        idle(1);
        check("wd_lost_pulse", 32'(lock_lost), 0);

        // G: next vs_fall clears no_signal
        run_frame(6, -1, 160);
        check("G_no_signal", 32'(no_signal), 0);

        // H completes G, then reset mid-frame
        run_frame(8, -1, 160);
        check("H_h_total", 32'(c_ht), 15);
        check("H_h_active", 32'(c_ha), 6);
        run_frame(8, -1, 40);
        reset_n = 1'b0;
        #1;
        check("mid_rst_h_total", 32'(h_total_meas), 0);
        check("mid_rst_h_active", 32'(h_active_meas), 0);
        check("mid_rst_v_total", 32'(v_total_meas), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_crc", 32'(frame_crc), 32'(exp_crc_rst));
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // I arms, J completes I, K locks
        run_frame(8, -1, 160);
        check("I_no_done", fd_cnt, 0);
        run_frame(8, -1, 160);
        check("J_done_cnt", fd_cnt, 1);
        check("J_v_active", 32'(c_va), 5);
        check("J_v_total", 32'(c_vt), 9);
        run_frame(8, -1, 160);
        check("K_locked", 32'(c_locked), 1);

`ifdef VGA_TIMING_MONITOR_CRC_EN
        // L carries one altered pixel; its completion drops lock
        run_frame(8, 17, 160);
        run_frame(8, -1, 160);
        check("L_crc", 32'(c_crc), 32'(crc_ref(40, 17)));
        check("L_locked", 32'(c_locked), 0);
        check("L_lock_lost", 32'(c_lost), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
